gfp8_group_accumulator: RTL and testbench



---
 rtl/gfp8_group_accumulator.sv | 97 +++++++++
 tb/tb_gfp8_group_accumulator.sv | 136 +++++++++++++
 2 files changed

// File: rtl/gfp8_group_accumulator.sv
// gfp8_group_accumulator: exponent-aligns and sums NUM_GROUPS group results into one GFP block result
module gfp8_group_accumulator #(
  parameter int NUM_GROUPS = 4,
  parameter int ACC_W = 40
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_mantissa,
  input  logic [7:0]       i_exponent,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACC_W-1:0] o_mantissa,
  output logic [7:0]       o_exponent,
  output logic [7:0]       o_group_cnt
);
  typedef enum logic {ACCUM, DONE} state_t;
  localparam logic [31:0] SH_MAX = 32'(ACC_W - 1);
  localparam logic [8:0] LAST = 9'(NUM_GROUPS - 1);
  state_t state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, m_ext, sum;
  logic signed [7:0] acc_exp_q, acc_exp_d, exp_sum;
  logic acc_nz_q, acc_nz_d;
  logic [8:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] out_m_q, out_m_d;
  logic [7:0] out_e_q, out_e_d;
  logic signed [8:0] d;
  logic [31:0] mag, sh;
  logic in_xfer, out_xfer;
  // Align the smaller-exponent operand to the larger exponent, clamping huge shifts so the operand collapses to 0/-1
  always_comb begin
    m_ext = ACC_W'(signed'(i_mantissa));
    d = {i_exponent[7], i_exponent} - {acc_exp_q[7], acc_exp_q};
    mag = 32'(d[8] ? -d : d);
    sh = mag > SH_MAX ? SH_MAX : mag;
    sum = d > 0 ? (acc_q >>> sh) + m_ext : acc_q + (m_ext >>> sh);
    exp_sum = d > 0 ? i_exponent : acc_exp_q;
  end
  // Handshake FSM: accumulate until the last group, then hold the result until it is taken
  always_comb begin
    in_xfer = i_valid && state_q == ACCUM;
    out_xfer = i_ready && state_q == DONE;
    state_d = state_q;
    acc_d = acc_q;
    acc_exp_d = acc_exp_q;
    acc_nz_d = acc_nz_q;
    cnt_d = cnt_q;
    out_m_d = out_m_q;
    out_e_d = out_e_q;
    if (in_xfer) begin
      cnt_d = cnt_q + 9'd1;
      if (i_mantissa != 32'd0) begin
        acc_d = acc_nz_q ? sum : m_ext;
        acc_exp_d = acc_nz_q ? exp_sum : i_exponent;
        acc_nz_d = 1'b1;
      end
      if (cnt_q == LAST) begin
        state_d = DONE;
        out_m_d = acc_d;
        out_e_d = acc_exp_d;
      end
    end
    if (out_xfer) begin
      state_d = ACCUM;
      acc_d = '0;
      acc_exp_d = '0;
      acc_nz_d = 1'b0;
      cnt_d = '0;
    end
  end
  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ACCUM;
      acc_q <= '0;
      acc_exp_q <= '0;
      acc_nz_q <= 1'b0;
      cnt_q <= '0;
      out_m_q <= '0;
      out_e_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      acc_exp_q <= acc_exp_d;
      acc_nz_q <= acc_nz_d;
      cnt_q <= cnt_d;
      out_m_q <= out_m_d;
      out_e_q <= out_e_d;
    end
  end
  assign o_ready = state_q == ACCUM;
  assign o_valid = state_q == DONE;
  assign o_mantissa = out_m_q;
  assign o_exponent = out_e_q;
  assign o_group_cnt = cnt_q[7:0];
endmodule

// File: tb/tb_gfp8_group_accumulator.sv
// tb_gfp8_group_accumulator: directed scoreboard bench for the GFP8 group accumulator
module tb_gfp8_group_accumulator;
  localparam int ACC_W = 40;
  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_valid = 1'b0;
  logic o_ready;
  logic [31:0] i_mantissa = '0;
  logic [7:0] i_exponent = '0;
  logic o_valid;
  logic i_ready = 1'b1;
  logic [ACC_W-1:0] o_mantissa;
  logic [7:0] o_exponent;
  logic [7:0] o_group_cnt;
  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];
  logic [47:0] hold;
  gfp8_group_accumulator #(.NUM_GROUPS(4), .ACC_W(ACC_W)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_mantissa(i_mantissa), .i_exponent(i_exponent), .o_valid(o_valid),
    .i_ready(i_ready), .o_mantissa(o_mantissa), .o_exponent(o_exponent),
    .o_group_cnt(o_group_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [47:0] res(input int m, input int e);
    return {40'(m), 8'(e)};
  endfunction
  task automatic send(input int m, input int e);
    int n;
    i_valid = 1'b1;
    i_mantissa = 32'(m);
    i_exponent = 8'(e);
    n = 0;
    while (!o_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", 64'({o_mantissa, o_exponent}), 64'hDEAD);
      else chk("result", 64'({o_mantissa, o_exponent}), 64'(exp_q.pop_front()));
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_mant", 64'(o_mantissa), 64'd0);
    chk("rst_exp", 64'(o_exponent), 64'd0);
    chk("rst_cnt", 64'(o_group_cnt), 64'd0);
    exp_q.push_back(res(100, -3));
    send(100, -3); send(-20, -3); send(5, -3);
    chk("lat_not_yet", 64'(o_valid), 64'd0);
    send(15, -3);
    chk("lat_valid", 64'(o_valid), 64'd1);
    chk("done_ready", 64'(o_ready), 64'd0);
    chk("done_cnt", 64'(o_group_cnt), 64'd4);
    @(posedge clk); #1;
    chk("one_cycle_valid", 64'(o_valid), 64'd0);
    chk("turn_ready", 64'(o_ready), 64'd1);
    chk("turn_cnt", 64'(o_group_cnt), 64'd0);
    exp_q.push_back(res(24, 2));
    send(64, 0); send(8, 2);
    chk("mid_cnt", 64'(o_group_cnt), 64'd2);
    send(-4, -1); send(1, 2);
    @(posedge clk); #1;
    exp_q.push_back(res(7, -9));
    send(0, 0); send(0, 0); send(7, -9); send(0, 0);
    @(posedge clk); #1;
    exp_q.push_back(res(0, 0));
    send(0, 0); send(0, 0); send(0, 0); send(0, 0);
    @(posedge clk); #1;
    exp_q.push_back(res(999, 60));
    send(1000, 60); send(-5, -60); send(0, 0); send(0, 0);
    @(posedge clk); #1;
    i_ready = 1'b0;
    exp_q.push_back(res(100, 0));
    send(10, 0); send(20, 0); send(30, 0); send(40, 0);
    i_valid = 1'b1;
    i_mantissa = 32'd12345;
    i_exponent = 8'd5;
    hold = {o_mantissa, o_exponent};
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready", 64'(o_ready), 64'd0);
      chk("bp_valid", 64'(o_valid), 64'd1);
      chk("bp_stable", 64'({o_mantissa, o_exponent}), 64'(hold));
      chk("bp_value", 64'({o_mantissa, o_exponent}), 64'(res(100, 0)));
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk("release_ready", 64'(o_ready), 64'd1);
    chk("release_valid", 64'(o_valid), 64'd0);
    exp_q.push_back(res(-14, 3));
    send(-7, 3); send(-7, 3); send(2, 1); send(0, 0);
    @(posedge clk); #1;
    send(5, 0); send(6, 0);
    i_valid = 1'b1;
    i_mantissa = 32'd9;
    i_exponent = 8'd0;
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
    chk("rstmid_valid", 64'(o_valid), 64'd0);
    chk("rstmid_cnt", 64'(o_group_cnt), 64'd0);
    chk("rstmid_ready", 64'(o_ready), 64'd1);
    exp_q.push_back(res(4, 0));
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
